microwave_timer_ctrl: RTL and testbench

- Parametrised single-block successor to the microwave oven controller.
- Merges into one clocked block:
  - the keypad time entry,
  - the 1 Hz tick divider,
  - the BCD countdown,
  - the magnetron control.
- Adds:
  - configurable minute-digit count,
  - pause/resume,
  - power-level duty cycling,
  - an end-of-cook beep.
- Drives the existing 7-segment decoder with a packed BCD bus.

---
 rtl/microwave_pkg.sv | 31 +++
 rtl/bcd_down_counter.sv | 73 +++++++
 rtl/microwave_timer_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer controller: state codes, BCD limits
// and keypad decoding helpers.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    function automatic logic [3:0] key_to_bcd(input logic [9:0] keys);
        logic [3:0] digit;
        digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (keys[k]) begin
                digit = 4'(k);
            end
        end
        return digit;
    endfunction

    function automatic logic key_is_one_hot(input logic [9:0] keys);
        return (keys != 10'd0) && ((keys & (keys - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Packed BCD time register with digit shift-in, clear and a one-second decrement
// whose tens-of-seconds digit reloads 5 on borrow.
module bcd_down_counter
    import microwave_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clr,
    input  logic              shift,
    input  logic [3:0]        digit,
    input  logic              dec,
    output logic [4*NDIG-1:0] bcd,
    output logic              zero
);

    localparam int W = 4 * NDIG;

    logic [W-1:0] bcd_r;
    logic [W-1:0] dec_s;
    logic [W-1:0] base_s;
    logic [W-1:0] next_s;
    logic         zero_r;

    // Borrow chain: tens-of-seconds reloads 5, every other digit reloads 9
    always_comb begin
        logic borrow;
        dec_s  = bcd_r;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (bcd_r[4*i +: 4] == 4'd0) begin
                    dec_s[4*i +: 4] = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
                end else begin
                    dec_s[4*i +: 4] = bcd_r[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end else begin
                dec_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Next value: a clear combined with a shift yields just the new digit
    always_comb begin
        base_s = clr ? {W{1'b0}} : bcd_r;
        if (shift) begin
            next_s = {base_s[W-5:0], digit};
        end else if (clr) begin
            next_s = {W{1'b0}};
        end else if (dec && !zero_r) begin
            next_s = dec_s;
        end else begin
            next_s = bcd_r;
        end
    end

    // Time and zero flag registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bcd_r  <= {W{1'b0}};
            zero_r <= 1'b1;
        end else begin
            bcd_r  <= next_s;
            zero_r <= (next_s == {W{1'b0}});
        end
    end

    assign bcd  = bcd_r;
    assign zero = zero_r;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave oven timer: keypad entry, 1 s tick divider, BCD countdown, pause/resume,
// power-level duty cycling of the magnetron and an end-of-cook beep.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int MIN_DIGITS = 2,
    parameter int PWR_PERIOD = 10,
    parameter int BEEP_TICKS = 3
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [9:0]                    keypad,
    input  logic                          startn,
    input  logic                          stopn,
    input  logic                          clearn,
    input  logic                          door_closed,
    input  logic [3:0]                    power,
    output logic [4*(MIN_DIGITS+2)-1:0]   bcd,
    output logic                          magnetron_on,
    output logic                          beep,
    output logic                          zero,
    output logic [2:0]                    state
);

    localparam int NDIG  = MIN_DIGITS + 2;
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int PH_W  = (PWR_PERIOD > 1) ? $clog2(PWR_PERIOD) : 1;
    localparam int BP_W  = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PWR_PERIOD - 1);
    localparam logic [BP_W-1:0]   BP_LAST  = BP_W'(BEEP_TICKS - 1);
    localparam logic [4*NDIG-1:0] BCD_ONE  = (4*NDIG)'(1);

    state_t            state_r, state_n;
    logic [DIV_W-1:0]  div_r, div_n, div_inc_s;
    logic [PH_W-1:0]   phase_r, phase_n, phase_tick_s;
    logic [3:0]        pwr_r, pwr_n;
    logic [BP_W-1:0]   beep_cnt_r, beep_cnt_n;
    logic              beep_r, mag_r, mag_n, full_pwr_s;
    logic              start_prev_r, stop_prev_r, clear_prev_r;
    logic [9:0]        key_prev_r;
    logic              start_ev_s, stop_ev_s, clear_ev_s, key_ev_s, tick_s;
    logic              cnt_clr_s, cnt_shift_s, cnt_dec_s;
    logic [4*NDIG-1:0] bcd_s;
    logic              zero_s;

    assign start_ev_s   = start_prev_r & ~startn;
    assign stop_ev_s    = stop_prev_r & ~stopn;
    assign clear_ev_s   = clear_prev_r & ~clearn;
    assign key_ev_s     = (key_prev_r == 10'd0) && key_is_one_hot(keypad);
    assign tick_s       = (div_r == DIV_LAST);
    assign div_inc_s    = tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
    assign phase_tick_s = !tick_s ? phase_r :
                          (phase_r == PH_LAST) ? {PH_W{1'b0}} : phase_r + PH_W'(1);

    bcd_down_counter #(
        .NDIG (NDIG)
    ) u_counter (
        .clock  (clock),
        .resetn (resetn),
        .clr    (cnt_clr_s),
        .shift  (cnt_shift_s),
        .digit  (key_to_bcd(keypad)),
        .dec    (cnt_dec_s),
        .bcd    (bcd_s),
        .zero   (zero_s)
    );

    // Next-state logic; event priority is clear > door open > stop > start > key/tick
    always_comb begin
        state_n     = state_r;
        div_n       = div_r;
        phase_n     = phase_r;
        pwr_n       = pwr_r;
        beep_cnt_n  = beep_cnt_r;
        cnt_clr_s   = 1'b0;
        cnt_shift_s = 1'b0;
        cnt_dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                div_n = {DIV_W{1'b0}};
                if (key_ev_s) begin
                    cnt_clr_s   = 1'b1;
                    cnt_shift_s = 1'b1;
                    state_n     = ST_ENTRY;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                div_n = {DIV_W{1'b0}};
                if (clear_ev_s) begin
                    cnt_clr_s = 1'b1;
                    state_n   = ST_IDLE;
                end else if (start_ev_s && door_closed && !zero_s) begin
                    state_n = ST_COOKING;
                    pwr_n   = power;
                    phase_n = {PH_W{1'b0}};
                end else if (key_ev_s) begin
                    cnt_shift_s = 1'b1;
                end else begin
                    state_n = ST_ENTRY;
                end
            end
            ST_COOKING: begin
                div_n     = div_inc_s;
                cnt_dec_s = tick_s;
                phase_n   = phase_tick_s;
                if (clear_ev_s) begin
                    cnt_clr_s = 1'b1;
                    state_n   = ST_IDLE;
                    div_n     = {DIV_W{1'b0}};
                end else if (!door_closed || stop_ev_s) begin
                    state_n = ST_PAUSED;
                end else if (zero_s || (tick_s && (bcd_s == BCD_ONE))) begin
                    state_n    = ST_DONE;
                    div_n      = {DIV_W{1'b0}};
                    beep_cnt_n = {BP_W{1'b0}};
                end else begin
                    state_n = ST_COOKING;
                end
            end
            ST_PAUSED: begin
                if (clear_ev_s || stop_ev_s) begin
                    cnt_clr_s = 1'b1;
                    state_n   = ST_IDLE;
                    div_n     = {DIV_W{1'b0}};
                end else if (start_ev_s && door_closed) begin
                    state_n = ST_COOKING;
                end else begin
                    state_n = ST_PAUSED;
                end
            end
            ST_DONE: begin
                div_n = div_inc_s;
                if (clear_ev_s || stop_ev_s) begin
                    cnt_clr_s = 1'b1;
                    state_n   = ST_IDLE;
                    div_n     = {DIV_W{1'b0}};
                end else if (key_ev_s) begin
                    cnt_clr_s   = 1'b1;
                    cnt_shift_s = 1'b1;
                    state_n     = ST_ENTRY;
                    div_n       = {DIV_W{1'b0}};
                end else if (tick_s) begin
                    if (beep_cnt_r == BP_LAST) begin
                        state_n = ST_IDLE;
                        div_n   = {DIV_W{1'b0}};
                    end else begin
                        beep_cnt_n = beep_cnt_r + BP_W'(1);
                    end
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_n   = ST_IDLE;
                div_n     = {DIV_W{1'b0}};
            end
        endcase
    end

    // Outputs are computed from next-state values so they line up with the state register
    always_comb begin
        full_pwr_s = (pwr_n == 4'd0) || (32'(pwr_n) > 32'(PWR_PERIOD));
        mag_n      = (state_n == ST_COOKING) && door_closed &&
                     (full_pwr_s || (32'(phase_n) < 32'(pwr_n)));
    end

    // State, divider, duty phase, beep timer and button history registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            div_r        <= {DIV_W{1'b0}};
            phase_r      <= {PH_W{1'b0}};
            pwr_r        <= 4'd0;
            beep_cnt_r   <= {BP_W{1'b0}};
            beep_r       <= 1'b0;
            mag_r        <= 1'b0;
            start_prev_r <= 1'b1;
            stop_prev_r  <= 1'b1;
            clear_prev_r <= 1'b1;
            key_prev_r   <= 10'd0;
        end else begin
            state_r      <= state_n;
            div_r        <= div_n;
            phase_r      <= phase_n;
            pwr_r        <= pwr_n;
            beep_cnt_r   <= beep_cnt_n;
            beep_r       <= (state_n == ST_DONE);
            mag_r        <= mag_n;
            start_prev_r <= startn;
            stop_prev_r  <= stopn;
            clear_prev_r <= clearn;
            key_prev_r   <= keypad;
        end
    end

    assign bcd          = bcd_s;
    assign zero         = zero_s;
    assign beep         = beep_r;
    assign magnetron_on = mag_r;
    assign state        = state_r;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl: stimulus queues expected snapshots
// tagged with a cycle number, a negedge monitor pops and compares them.
module tb_microwave_timer_ctrl;

    logic        clock       = 1'b0;
    logic        resetn      = 1'b0;
    logic [9:0]  keypad      = 10'd0;
    logic        startn      = 1'b1;
    logic        stopn       = 1'b1;
    logic        clearn      = 1'b1;
    logic        door_closed = 1'b1;
    logic [3:0]  power       = 4'd0;
    logic [15:0] bcd;
    logic        magnetron_on, beep, zero;
    logic [2:0]  state;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic [2:0]  st;
        logic        mag;
        logic        beep;
        logic        zero;
    } exp_t;

    exp_t        sb[$];
    string       nm[$];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] cd_tab [6];

    microwave_timer_ctrl #(
        .TICK_DIV   (4),
        .MIN_DIGITS (2),
        .PWR_PERIOD (4),
        .BEEP_TICKS (2)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .keypad       (keypad),
        .startn       (startn),
        .stopn        (stopn),
        .clearn       (clearn),
        .door_closed  (door_closed),
        .power        (power),
        .bcd          (bcd),
        .magnetron_on (magnetron_on),
        .beep         (beep),
        .zero         (zero),
        .state        (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every queued snapshot that falls due in this cycle
    always @(negedge clock) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                total++;
                if (sb[i].cyc < cyc || bcd !== sb[i].bcd || state !== sb[i].st ||
                    magnetron_on !== sb[i].mag || beep !== sb[i].beep || zero !== sb[i].zero) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got bcd=%h st=%0d mag=%b beep=%b zero=%b want bcd=%h st=%0d mag=%b beep=%b zero=%b",
                             nm[i], cyc, bcd, state, magnetron_on, beep, zero,
                             sb[i].bcd, sb[i].st, sb[i].mag, sb[i].beep, sb[i].zero);
                end
                sb.delete(i);
                nm.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int lat, input string name, input logic [15:0] b,
                            input logic [2:0] s, input logic m, input logic bp, input logic z);
        exp_t e;
        e.cyc  = cyc + lat;
        e.bcd  = b;
        e.st   = s;
        e.mag  = m;
        e.beep = bp;
        e.zero = z;
        sb.push_back(e);
        nm.push_back(name);
    endtask

    task automatic press_key(input int d);
        keypad = 10'd1 << d;
        step(1);
        keypad = 10'd0;
        step(1);
    endtask

    task automatic press_start();
        startn = 1'b0;
        step(1);
        startn = 1'b1;
        step(1);
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        step(1);
        stopn = 1'b1;
        step(1);
    endtask

    task automatic press_clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        step(1);
    endtask

    initial begin
        #100000;
        total++;
        bad++;
        $display("FAIL timeout cyc=%0d pending=%0d want pending=0", cyc, sb.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        cd_tab = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};
        step(2);
        push_exp(0, "reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1);
        resetn = 1'b1;
        step(1);

        // Entry 1,0,5 and countdown through the minute boundary
        press_key(1);
        push_exp(0, "key1", 16'h0001, 3'd1, 1'b0, 1'b0, 1'b0);
        press_key(0);
        press_key(5);
        push_exp(0, "entry105", 16'h0105, 3'd1, 1'b0, 1'b0, 1'b0);
        push_exp(1, "cook_start", 16'h0105, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(4, "pre_tick", 16'h0105, 3'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            push_exp(1 + 4 * k, "countdown", cd_tab[k-1], 3'd2, 1'b1, 1'b0, 1'b0);
        end
        press_start();
        step(24);

        // Asynchronous reset while cooking, checked before any further clock edge
        push_exp(0, "async_reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
        #1 resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        step(1);

        // Count 0:02 down to DONE, beep for two ticks, back to IDLE
        press_key(2);
        push_exp(0, "entry002", 16'h0002, 3'd1, 1'b0, 1'b0, 1'b0);
        push_exp(1, "done_start", 16'h0002, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(5, "done_tick1", 16'h0001, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(8, "done_pre", 16'h0001, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(9, "done_enter", 16'h0000, 3'd4, 1'b0, 1'b1, 1'b1);
        push_exp(16, "beep_last", 16'h0000, 3'd4, 1'b0, 1'b1, 1'b1);
        push_exp(17, "beep_end", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
        press_start();
        step(16);

        // Pause on door open, resume from the held divider, stop twice to IDLE
        press_key(1);
        press_key(5);
        push_exp(0, "entry015", 16'h0015, 3'd1, 1'b0, 1'b0, 1'b0);
        press_start();
        step(4);
        push_exp(0, "pre_pause", 16'h0014, 3'd2, 1'b1, 1'b0, 1'b0);
        door_closed = 1'b0;
        push_exp(1, "pause_enter", 16'h0014, 3'd3, 1'b0, 1'b0, 1'b0);
        step(6);
        push_exp(0, "pause_hold", 16'h0014, 3'd3, 1'b0, 1'b0, 1'b0);
        door_closed = 1'b1;
        startn      = 1'b0;
        push_exp(1, "resume", 16'h0014, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(2, "resume_div", 16'h0014, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(3, "resume_tick", 16'h0013, 3'd2, 1'b1, 1'b0, 1'b0);
        step(1);
        startn = 1'b1;
        step(2);
        press_stop();
        push_exp(0, "stop_pause", 16'h0013, 3'd3, 1'b0, 1'b0, 1'b0);
        press_stop();
        push_exp(0, "stop_idle", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);

        // Power level 1 of 4: on only in phase 0
        power = 4'd1;
        press_key(8);
        push_exp(0, "entry008", 16'h0008, 3'd1, 1'b0, 1'b0, 1'b0);
        push_exp(1, "pwr_on", 16'h0008, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(4, "pwr_on_end", 16'h0008, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(5, "pwr_off", 16'h0007, 3'd2, 1'b0, 1'b0, 1'b0);
        push_exp(13, "pwr_off3", 16'h0005, 3'd2, 1'b0, 1'b0, 1'b0);
        push_exp(17, "pwr_wrap", 16'h0004, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(20, "pwr_wrap_end", 16'h0004, 3'd2, 1'b1, 1'b0, 1'b0);
        push_exp(21, "pwr_off_again", 16'h0003, 3'd2, 1'b0, 1'b0, 1'b0);
        press_start();
        step(19);
        press_clear();
        push_exp(0, "clear_cook", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);

        // Power 0 means full power in every phase
        power = 4'd0;
        press_key(3);
        push_exp(5, "full_pwr", 16'h0002, 3'd2, 1'b1, 1'b0, 1'b0);
        press_start();
        step(4);
        press_clear();
        push_exp(0, "clear_full", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);

        // Multi-key press ignored until keypad returns to all-zero
        keypad = 10'h006;
        step(1);
        keypad = 10'h002;
        step(1);
        keypad = 10'd0;
        step(1);
        push_exp(0, "two_keys", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);

        // Five digits: the top digit falls off
        for (int d = 1; d <= 4; d++) begin
            press_key(d);
        end
        push_exp(0, "four_digits", 16'h1234, 3'd1, 1'b0, 1'b0, 1'b0);
        press_key(5);
        push_exp(0, "drop_top", 16'h2345, 3'd1, 1'b0, 1'b0, 1'b0);

        door_closed = 1'b0;
        press_start();
        push_exp(0, "start_door_open", 16'h2345, 3'd1, 1'b0, 1'b0, 1'b0);
        door_closed = 1'b1;

        // Start with zero time is ignored
        press_clear();
        press_key(0);
        push_exp(0, "entry_zero", 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1);
        press_start();
        push_exp(0, "start_zero", 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1);

        // Clear beats start in the same cycle
        press_key(7);
        push_exp(0, "entry007", 16'h0007, 3'd1, 1'b0, 1'b0, 1'b0);
        clearn = 1'b0;
        startn = 1'b0;
        step(1);
        clearn = 1'b1;
        startn = 1'b1;
        step(1);
        push_exp(0, "clear_start", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);

        step(3);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want pending=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
